// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared defaults and counter sizing for the button conditioner
//
// Purpose : default configuration constants and a width helper used by
//           btn_chan and btn_conditioner.
// Ports   : none (package).
package btn_cond_pkg;

  localparam int DB_CYCLES_DEF     = 4;
  localparam int REPEAT_DELAY_DEF  = 8;
  localparam int REPEAT_PERIOD_DEF = 4;

  // ceil(log2(n)), never below 1, so a counter holding 0..n-1 always has a bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// rtl/btn_chan.sv - one button channel: synchronizer, debounce filter, edge pulses
//
// Purpose : conditions one raw asynchronous input into a clean level plus
//           registered one-cycle rise/fall pulses. Optional auto-repeat of the
//           rise pulse while held, enabled by `define BTN_COND_AUTOREPEAT_EN.
// Ports   : clk    in   system clock, rising edge
//           reset  in   synchronous, active-high reset
//           raw    in   raw asynchronous input
//           level  out  debounced, synchronized level
//           rise   out  one-cycle pulse on accepted 0->1 (plus repeats)
//           fall   out  one-cycle pulse on accepted 1->0
module btn_chan
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              DB_W    = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;
  logic            differs;
  logic            accept;
  logic            press;
  logic            pulse_rise;

  assign differs = (sync2 != level);
  // Acceptance happens on the edge where the counter has already seen
  // DB_CYCLES-1 differing cycles and the current one still differs.
  assign accept  = differs && (db_cnt == DB_LAST);
  assign press   = accept && !level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any return to the current level clears the count, so glitches
      // shorter than DB_CYCLES never reach acceptance.
      if (!differs || accept) db_cnt <= '0;
      else                    db_cnt <= db_cnt + 1'b1;
      if (accept) level <= sync2;
    end
  end

`ifdef BTN_COND_AUTOREPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = cnt_width(RP_MAX);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic [RP_W-1:0] rp_cnt;
  logic            rp_periodic;
  logic            held;
  logic            rp_fire;

  // A release being accepted this edge counts as not held, so no repeat
  // pulse can coincide with the fall pulse.
  assign held    = level && !accept;
  assign rp_fire = held && (rp_cnt == (rp_periodic ? PERIOD_LAST : DELAY_LAST));

  always_ff @(posedge clk) begin
    if (reset || !held) begin
      rp_cnt      <= '0;
      rp_periodic <= 1'b0;
    end else if (rp_fire) begin
      rp_cnt      <= '0;
      rp_periodic <= 1'b1;
    end else begin
      rp_cnt <= rp_cnt + 1'b1;
    end
  end

  assign pulse_rise = press || rp_fire;
`else
  // Keeps the repeat parameters referenced when the feature is compiled out.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);

  assign pulse_rise = press;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= pulse_rise;
      fall <= accept && level;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_BTN independent button conditioning channels
//
// Purpose : wiring-only top; one btn_chan per input bit. Auto-repeat is
//           enabled by `define BTN_COND_AUTOREPEAT_EN.
// Ports   : clk        in   system clock, rising edge
//           reset      in   synchronous, active-high reset
//           btn_raw    in   [N_BTN] raw asynchronous inputs
//           btn_level  out  [N_BTN] debounced, synchronized levels
//           btn_rise   out  [N_BTN] one-cycle press (and repeat) pulses
//           btn_fall   out  [N_BTN] one-cycle release pulses
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN         = 2,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (btn_rise[i]),
      .fall (btn_fall[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] btn_fall;

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  btn_conditioner #(.N_BTN(2), .DB_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  always #5 clk = ~clk;

  // Iteration i: inputs set before edge i, outputs observed 1 time unit after edge i.

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      reset   = (i <= 2);
      btn_raw = 2'b11;
      e.lvl   = (i >= 8) ? 2'b11 : 2'b00;
      e.rise  = (i == 8) ? 2'b11 : 2'b00;
      e.fall  = 2'b00;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({btn_level, btn_rise, btn_fall} !== e) begin
        errors++;
        $display("FAIL reset cyc %0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 i, btn_level, btn_rise, btn_fall, e.lvl, e.rise, e.fall);
      end
    end
  endtask

  task automatic test_clean_press();
    exp_t e;
    for (int i = 0; i <= 12; i++) begin
      reset   = (i == 0);
      btn_raw = (i >= 2) ? 2'b01 : 2'b00;
      e.lvl   = (i >= 7) ? 2'b01 : 2'b00;
      e.rise  = (i == 7) ? 2'b01 : 2'b00;
      e.fall  = 2'b00;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({btn_level, btn_rise, btn_fall} !== e) begin
        errors++;
        $display("FAIL clean_press cyc %0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 i, btn_level, btn_rise, btn_fall, e.lvl, e.rise, e.fall);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    logic [0:26] pat;
    // 3-cycle pulse, bounce 1,0,1,1,0, then stable 1 from iteration 18.
    pat = 27'b0_111_000000000_10110_111111111;
    for (int i = 0; i <= 26; i++) begin
      reset   = (i == 0);
      btn_raw = {pat[i], 1'b0};
      e.lvl   = (i >= 23) ? 2'b10 : 2'b00;
      e.rise  = (i == 23) ? 2'b10 : 2'b00;
      e.fall  = 2'b00;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({btn_level, btn_rise, btn_fall} !== e) begin
        errors++;
        $display("FAIL glitch cyc %0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 i, btn_level, btn_rise, btn_fall, e.lvl, e.rise, e.fall);
      end
    end
  endtask

  task automatic test_release();
    exp_t e;
    for (int i = 0; i <= 15; i++) begin
      reset   = (i == 0);
      btn_raw = (i >= 1 && i < 7) ? 2'b01 : 2'b00;
      e.lvl   = (i >= 6 && i < 12) ? 2'b01 : 2'b00;
      e.rise  = (i == 6) ? 2'b01 : 2'b00;
      e.fall  = (i == 12) ? 2'b01 : 2'b00;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({btn_level, btn_rise, btn_fall} !== e) begin
        errors++;
        $display("FAIL release cyc %0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 i, btn_level, btn_rise, btn_fall, e.lvl, e.rise, e.fall);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i <= 13; i++) begin
      reset   = (i == 0 || i == 4);
      btn_raw = (i >= 1) ? 2'b01 : 2'b00;
      e.lvl   = (i >= 10) ? 2'b01 : 2'b00;
      e.rise  = (i == 10) ? 2'b01 : 2'b00;
      e.fall  = 2'b00;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({btn_level, btn_rise, btn_fall} !== e) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 i, btn_level, btn_rise, btn_fall, e.lvl, e.rise, e.fall);
      end
    end
  endtask

  task automatic test_independent();
    exp_t e;
    for (int i = 0; i <= 15; i++) begin
      reset      = (i == 0);
      btn_raw[0] = (i >= 1 && i < 8);
      btn_raw[1] = (i >= 3);
      e.lvl  = {(i >= 8), (i >= 6 && i < 13)};
      e.rise = {(i == 8), (i == 6)};
      e.fall = {1'b0, (i == 13)};
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({btn_level, btn_rise, btn_fall} !== e) begin
        errors++;
        $display("FAIL independent cyc %0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 i, btn_level, btn_rise, btn_fall, e.lvl, e.rise, e.fall);
      end
    end
  endtask

`ifdef BTN_COND_AUTOREPEAT_EN
  task automatic test_autorepeat();
    exp_t e;
    // Level rises at T=6; repeats at T+8, then every 4; raw released at 31 -> fall at 36.
    for (int i = 0; i <= 40; i++) begin
      reset   = (i == 0);
      btn_raw = (i >= 1 && i <= 30) ? 2'b01 : 2'b00;
      e.lvl   = (i >= 6 && i < 36) ? 2'b01 : 2'b00;
      e.rise  = (i == 6 || (i >= 14 && i < 36 && ((i - 14) % 4) == 0)) ? 2'b01 : 2'b00;
      e.fall  = (i == 36) ? 2'b01 : 2'b00;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({btn_level, btn_rise, btn_fall} !== e) begin
        errors++;
        $display("FAIL autorepeat cyc %0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 i, btn_level, btn_rise, btn_fall, e.lvl, e.rise, e.fall);
      end
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_clean_press();
    test_glitch();
    test_release();
    test_reset_mid();
    test_independent();
`ifdef BTN_COND_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
